disp_page_ctrl: RTL and testbench
=================================

Name: disp_page_ctrl

Overview:
- Shares the 8-digit scan display between NUM_SRC independent 32-bit data sources.
- Keeps a shadow register per source and selects one source as the current page.
- Pages are advanced by a debounced push-button, or automatically by a dwell timer.
- Drives the display's 32-bit data input (bit range [32:1]), and sits between the CPU/datapath debug taps and the display scanner.

Parameters:
- NUM_SRC, 4, number of sources (2..8).
- DEBOUNCE_MAX, 50000, consecutive stable cycles needed to accept a button level change.
- DWELL_CYCLES, 50000000, cycles per page in auto mode.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- src_data  input  NUM_SRC*32  packed source words; source i occupies [32*i+31:32*i].
- src_valid  input  NUM_SRC  source i offers a new word this cycle.
- src_ready  output  NUM_SRC  controller accepts source i's word this cycle.
- btn_next  input  1  raw, asynchronous, bouncing page-advance button, active-high.
- auto_en  input  1  level switch; 1 = auto-rotate pages.
- freeze  input  1  level switch; 1 = stop capturing new source data.
- disp_data  output  32 [32:1]  word to the display scanner.
- cur_src  output  3  index of the currently displayed source.
- upd_pulse  output  1  one-cycle strobe: displayed word changed due to new data.

Behaviour:
- Interface: one clock (clk); reset (rst_n) is asynchronous and active-low.
- Reset values:
  - all shadows = 0, sel = 0, cur_src = 0, disp_data = 0, upd_pulse = 0.
  - dwell counter = 0, debounce counter = 0, sync flops = 0, stable button = 0.
  - src_ready follows freeze combinationally: all 1 when freeze = 0, all 0 when freeze = 1.
- Capture: src_ready[i] = ~freeze for every i. On valid[i] & ready[i], shadow[i] <= src_data word i at the next edge. Sources are independent; simultaneous captures from different sources all complete in the same cycle.
- Button path:
  - 2-flop synchronizer, then the debouncer.
  - The debounce counter increments while the synchronized level differs from the stable level, and clears to 0 when they are equal.
  - When the counter reaches DEBOUNCE_MAX-1, stable <= synced and the counter clears.
  - A 0->1 transition of stable produces one advance request.
  - Worst-case latency from raw press to advance: 2 + DEBOUNCE_MAX + 1 cycles.
- Dwell timer:
  - Counts only while auto_en = 1; held at 0 while auto_en = 0.
  - On reaching DWELL_CYCLES-1, it produces one advance request and wraps to 0.
  - Any button advance also clears it.
- Advance: sel <= (sel == NUM_SRC-1) ? 0 : sel+1.
  - A button advance and a timer advance in the same cycle yield a single increment.
  - Paging is permitted while freeze = 1.
- Output register:
  - disp_data <= shadow[sel_next] each cycle, where sel_next is the value sel takes on that edge.
  - Net latency is 1 cycle from capture or advance to disp_data; cur_src mirrors the registered sel.
- upd_pulse = 1 for exactly one cycle, aligned with disp_data, when source sel_next is captured in the preceding edge's cycle. Page advances alone never raise upd_pulse.
- Reset asserted mid-operation returns everything to reset values immediately. A button held through reset release is treated as an accepted press only after a full debounce.
- cur_src bits above clog2(NUM_SRC) read 0.

Optional Feature:
- Macro: DISP_SRC_TAG_EN.
- Defined:
  - disp_data[32:29] = {1'b0, cur_src} (leftmost digit shows the page number).
  - disp_data[28:1] = shadow[sel][27:0].
  - upd_pulse fires only when bits [27:0] change value.
- Undefined: the full 32-bit shadow word is shown, and upd_pulse follows the capture rule above.

Test Plan (bench params NUM_SRC=4, DEBOUNCE_MAX=4, DWELL_CYCLES=10):
- Reset then capture: release rst_n, pulse src_valid[0] with 0x12345678 -> next edge disp_data=0x12345678, cur_src=0, upd_pulse high 1 cycle; src_valid[2] with 0xDEADBEEF -> disp_data unchanged, upd_pulse stays 0.
- Bouncy button: toggle btn_next 1/0 every cycle for 6 cycles, then hold 1 -> exactly one advance, cur_src=1, disp_data=shadow[1]; 3 quick presses (each held >=7 cycles) from page 3 -> cur_src wraps 3->0->1->2.
- Auto rotate: auto_en=1 from cur_src=0 -> cur_src increments every 10 cycles, 0->1->2->3->0; button advance at cycle 5 of a dwell -> single increment, next auto advance 10 cycles later.
- Simultaneous: button advance and timer expiry on the same edge -> cur_src increases by exactly 1.
- Freeze: freeze=1, src_valid[cur]=1 with 0xAAAA5555 -> src_ready=0, disp_data unchanged, no upd_pulse; paging still works; freeze=0 -> capture resumes.
- DISP_SRC_TAG_EN: cur_src=2, shadow[2]=0xFFFFFFFF -> disp_data=0x2FFFFFFF; reset mid-dwell -> cur_src=0, disp_data=0x00000000.

Source files
------------

// File: rtl/disp_page_ctrl.sv
// disp_page_ctrl
//   Multiplexes NUM_SRC independent 32-bit debug sources onto the 8-digit
//   scan display. Each source has a shadow register; one source is the
//   current page. Pages advance on a debounced push-button or on a dwell
//   timer when auto mode is on.
//
//   Ports
//     clk, rst_n           clock, async active-low reset
//     src_data/valid/ready per-source capture handshake (ready = ~freeze)
//     btn_next             raw bouncing page-advance button
//     auto_en              1 = rotate pages every DWELL_CYCLES
//     freeze               1 = stop capturing source data (paging still works)
//     disp_data[32:1]      registered word to the display scanner
//     cur_src              registered page index (upper bits read 0)
//     upd_pulse            one-cycle strobe, aligned with disp_data, when the
//                          shown page was refreshed by a capture
//
//   Build option
//     DISP_SRC_TAG_EN      leftmost digit shows the page number, lower 28 bits
//                          of the shadow are shown, upd_pulse only on a real
//                          change of those 28 bits.

module disp_page_shadow (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cap_i,
  input  logic [31:0] d_i,
  output logic [31:0] q_o
);
  logic [31:0] shadow_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     shadow_q <= '0;
    else if (cap_i) shadow_q <= d_i;
  end

  assign q_o = shadow_q;
endmodule

module disp_page_ctrl #(
  parameter int NUM_SRC      = 4,
  parameter int DEBOUNCE_MAX = 50000,
  parameter int DWELL_CYCLES = 50000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_SRC*32-1:0] src_data,
  input  logic [NUM_SRC-1:0]    src_valid,
  output logic [NUM_SRC-1:0]    src_ready,
  input  logic                  btn_next,
  input  logic                  auto_en,
  input  logic                  freeze,
  output logic [32:1]           disp_data,
  output logic [2:0]            cur_src,
  output logic                  upd_pulse
);
  localparam int SEL_W = $clog2(NUM_SRC);
  localparam int DB_W  = $clog2(DEBOUNCE_MAX + 1);
  localparam int DW_W  = $clog2(DWELL_CYCLES + 1);

  // ---------------- capture ----------------
  logic [NUM_SRC-1:0][31:0] word, shadow_q;
  logic [NUM_SRC-1:0]       cap;

  assign word      = src_data;
  assign src_ready = ~{NUM_SRC{freeze}};
  assign cap       = src_valid & src_ready;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    disp_page_shadow u_shadow (
      .clk   (clk),
      .rst_n (rst_n),
      .cap_i (cap[g]),
      .d_i   (word[g]),
      .q_o   (shadow_q[g])
    );
  end

  // ---------------- button sync + debounce ----------------
  logic            sync1_q, sync2_q;
  logic            stable_q, stable_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            btn_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      sync1_q  <= btn_next;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // Any cycle where the synced level agrees with the stable level restarts
  // the count, so only an unbroken run of DEBOUNCE_MAX cycles is accepted.
  always_comb begin
    stable_d = stable_q;
    db_cnt_d = '0;
    if (sync2_q != stable_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_MAX - 1)) stable_d = sync2_q;
      else                                     db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  // Advance on the edge where stable rises, so the new page lands together
  // with the debounced level.
  assign btn_adv = stable_d & ~stable_q;

  // ---------------- dwell timer ----------------
  logic [DW_W-1:0] dwell_q, dwell_d;
  logic            tmr_adv;

  assign tmr_adv = auto_en & (dwell_q == DW_W'(DWELL_CYCLES - 1));
  assign dwell_d = (!auto_en || btn_adv || tmr_adv) ? '0 : dwell_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dwell_q <= '0;
    else        dwell_q <= dwell_d;
  end

  // ---------------- page select + output register ----------------
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [31:0]      disp_q, disp_d, nxt_word;
  logic             upd_q, upd_d;
  logic             adv;

  // Coincident button and timer requests merge into one increment.
  assign adv   = btn_adv | tmr_adv;
  assign sel_d = !adv ? sel_q :
                 (sel_q == SEL_W'(NUM_SRC - 1)) ? '0 : sel_q + 1'b1;

  // Forward a same-cycle capture so the display sees it with one cycle of
  // latency rather than waiting for the shadow to be read back.
  assign nxt_word = cap[sel_d] ? word[sel_d] : shadow_q[sel_d];

`ifdef DISP_SRC_TAG_EN
  assign disp_d = {1'b0, 3'(sel_d), nxt_word[27:0]};
  assign upd_d  = cap[sel_d] & (word[sel_d][27:0] != shadow_q[sel_d][27:0]);
`else
  assign disp_d = nxt_word;
  assign upd_d  = cap[sel_d];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q  <= '0;
      disp_q <= '0;
      upd_q  <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      disp_q <= disp_d;
      upd_q  <= upd_d;
    end
  end

  assign disp_data = disp_q;
  assign cur_src   = 3'(sel_q);
  assign upd_pulse = upd_q;

endmodule

// File: tb/tb_disp_page_ctrl.sv
module tb_disp_page_ctrl;
  localparam int NS = 4, DM = 4, DW = 10;
`ifdef DISP_SRC_TAG_EN
  localparam bit TAG = 1'b1;
`else
  localparam bit TAG = 1'b0;
`endif

  logic              clk = 1'b0, rst_n = 1'b0;
  logic [NS*32-1:0]  src_data = '0;
  logic [NS-1:0]     src_valid = '0, src_ready;
  logic              btn_next = 1'b0, auto_en = 1'b0, freeze = 1'b0;
  logic [32:1]       disp_data;
  logic [2:0]        cur_src;
  logic              upd_pulse;

  int n_chk = 0, n_fail = 0;
  int lat = 0;
  logic [31:0] sh [NS];

  always #5 clk = ~clk;

  disp_page_ctrl #(.NUM_SRC(NS), .DEBOUNCE_MAX(DM), .DWELL_CYCLES(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .src_data  (src_data),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .btn_next  (btn_next),
    .auto_en   (auto_en),
    .freeze    (freeze),
    .disp_data (disp_data),
    .cur_src   (cur_src),
    .upd_pulse (upd_pulse)
  );

  typedef struct {
    logic [3:0]       valid;
    logic [3:0][31:0] w;
    logic             frz;
    logic [31:0]      exp_word;
    logic             exp_upd;
    logic [3:0]       exp_rdy;
  } vec_t;

  function automatic vec_t mkv(logic [3:0] v, logic [31:0] w3, logic [31:0] w2,
                               logic [31:0] w1, logic [31:0] w0, logic f,
                               logic [31:0] ew, logic eu, logic [3:0] er);
    vec_t r;
    r.valid = v; r.w = {w3, w2, w1, w0}; r.frz = f;
    r.exp_word = ew; r.exp_upd = eu; r.exp_rdy = er;
    return r;
  endfunction

  function automatic logic [31:0] exp_disp(logic [31:0] w, logic [2:0] c);
    return TAG ? {1'b0, c, w[27:0]} : w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic press();
    btn_next = 1'b1;
    repeat (8) step();
    btn_next = 1'b0;
    repeat (8) step();
  endtask

  vec_t vt [8];

  initial begin
    // junk in non-valid lanes must never be captured
    vt[0] = mkv(4'h1, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h12345678, 1'b0, 32'h12345678, 1'b1, 4'hF);
    vt[1] = mkv(4'h0, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h5A5A5A5A, 1'b0, 32'h12345678, 1'b0, 4'hF);
    vt[2] = mkv(4'h4, 32'h5A5A5A5A, 32'hDEADBEEF, 32'h5A5A5A5A, 32'h5A5A5A5A, 1'b0, 32'h12345678, 1'b0, 4'hF);
    vt[3] = mkv(4'h3, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h22222222, 32'h11111111, 1'b0, 32'h11111111, 1'b1, 4'hF);
    vt[4] = mkv(4'h1, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'hAAAA5555, 1'b1, 32'h11111111, 1'b0, 4'h0);
    vt[5] = mkv(4'h0, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h5A5A5A5A, 1'b0, 32'h11111111, 1'b0, 4'hF);
    vt[6] = mkv(4'h1, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'hAAAA5555, 1'b0, 32'hAAAA5555, 1'b1, 4'hF);
    vt[7] = mkv(4'h8, 32'h0BAD0F00, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h5A5A5A5A, 1'b0, 32'hAAAA5555, 1'b0, 4'hF);
    for (int j = 0; j < NS; j++) sh[j] = '0;

    // ---- reset state ----
    repeat (2) step();
    chk("rst disp", disp_data, 32'h0);
    chk("rst cur", cur_src, 3'd0);
    chk("rst upd", upd_pulse, 1'b0);
    chk("rst rdy", src_ready, 4'hF);
    freeze = 1'b1; #1;
    chk("rst rdy frz", src_ready, 4'h0);
    freeze = 1'b0;
    rst_n = 1'b1;
    step();

    // ---- capture table ----
    for (int i = 0; i < 8; i++) begin
      src_valid = vt[i].valid;
      src_data  = vt[i].w;
      freeze    = vt[i].frz;
      #1;
      chk($sformatf("v%0d rdy", i), src_ready, vt[i].exp_rdy);
      step();
      chk($sformatf("v%0d disp", i), disp_data, exp_disp(vt[i].exp_word, 3'd0));
      chk($sformatf("v%0d upd", i), upd_pulse, vt[i].exp_upd);
      chk($sformatf("v%0d cur", i), cur_src, 3'd0);
      for (int j = 0; j < NS; j++)
        if (vt[i].valid[j] && !vt[i].frz) sh[j] = vt[i].w[j];
    end
    src_valid = '0;
    freeze = 1'b0;
    step();
    chk("idle upd", upd_pulse, 1'b0);

    // ---- bouncy button: no advance while bouncing, one after holding ----
    for (int k = 0; k < 6; k++) begin
      btn_next = (k % 2 == 0);
      step();
    end
    chk("bounce no adv", cur_src, 3'd0);
    btn_next = 1'b1;
    lat = 0;
    while (cur_src == 3'd0 && lat < 2 + DM + 1) begin
      step();
      lat++;
    end
    chk("bounce adv", cur_src, 3'd1);
    chk("bounce disp", disp_data, exp_disp(sh[1], 3'd1));
    chk("bounce upd", upd_pulse, 1'b0);
    repeat (10) step();
    chk("hold single", cur_src, 3'd1);
    btn_next = 1'b0;
    repeat (10) step();
    chk("release no adv", cur_src, 3'd1);

    // ---- quick presses, wrap 3->0->1->2 ----
    press(); press();
    chk("page3", cur_src, 3'd3);
    chk("page3 disp", disp_data, exp_disp(sh[3], 3'd3));
    for (int p = 0; p < 3; p++) begin
      press();
      chk($sformatf("wrap p%0d", p), cur_src, 3'(p));
      chk($sformatf("wrap p%0d disp", p), disp_data, exp_disp(sh[p], 3'(p)));
    end
    press(); press();
    chk("to page0", cur_src, 3'd0);

    // ---- auto rotate ----
    auto_en = 1'b1;
    for (int p = 1; p <= 4; p++) begin
      repeat (DW - 1) step();
      chk($sformatf("dwell hold %0d", p), cur_src, 3'((p - 1) % NS));
      step();
      chk($sformatf("auto adv %0d", p), cur_src, 3'(p % NS));
      chk($sformatf("auto disp %0d", p), disp_data, exp_disp(sh[p % NS], 3'(p % NS)));
    end

    // button mid-dwell: single step, timer restarts from the button advance
    btn_next = 1'b1;
    lat = 0;
    while (cur_src == 3'd0 && lat < DW - 1) begin
      step();
      lat++;
    end
    btn_next = 1'b0;
    chk("btn in dwell", cur_src, 3'd1);
    chk("btn latency", (lat >= 1 && lat <= 2 + DM + 1), 1'b1);
    repeat (DW - 1) step();
    chk("dwell restart hold", cur_src, 3'd1);
    step();
    chk("dwell restart adv", cur_src, 3'd2);

    // button and timer on the same edge
    repeat (DW - lat) step();
    btn_next = 1'b1;
    repeat (lat) step();
    chk("simul single", cur_src, 3'd3);
    btn_next = 1'b0;
    repeat (DW - 1) step();
    chk("after simul hold", cur_src, 3'd3);
    step();
    chk("after simul adv", cur_src, 3'd0);
    auto_en = 1'b0;
    repeat (10) step();

    // ---- freeze: no capture, paging still allowed ----
    freeze = 1'b1;
    press();
    chk("frz page", cur_src, 3'd1);
    src_valid = 4'h2;
    src_data  = {32'h0, 32'h0, 32'hAAAA5555, 32'h0};
    step();
    chk("frz rdy", src_ready, 4'h0);
    chk("frz disp", disp_data, exp_disp(sh[1], 3'd1));
    chk("frz upd", upd_pulse, 1'b0);
    freeze = 1'b0;
    step();
    sh[1] = 32'hAAAA5555;
    chk("unfrz disp", disp_data, exp_disp(sh[1], 3'd1));
    chk("unfrz upd", upd_pulse, 1'b1);
    src_valid = '0;
    step();
    chk("unfrz upd drop", upd_pulse, 1'b0);

    // ---- page 2 all-ones word ----
    press();
    chk("page2", cur_src, 3'd2);
    src_valid = 4'h4;
    src_data  = {32'h0, 32'hFFFFFFFF, 32'h0, 32'h0};
    step();
    src_valid = '0;
    chk("ones disp", disp_data, exp_disp(32'hFFFFFFFF, 3'd2));
    chk("ones upd", upd_pulse, 1'b1);

    // ---- reset mid-dwell ----
    auto_en = 1'b1;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    chk("midrst cur", cur_src, 3'd0);
    chk("midrst disp", disp_data, 32'h0);
    chk("midrst upd", upd_pulse, 1'b0);
    for (int j = 0; j < NS; j++) sh[j] = '0;
    step();
    rst_n = 1'b1;
    repeat (DW - 1) step();
    chk("rst dwell hold", cur_src, 3'd0);
    step();
    chk("rst dwell adv", cur_src, 3'd1);
    auto_en = 1'b0;

    // ---- button held through reset release needs a full debounce ----
    btn_next = 1'b1;
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (2 + DM - 1) step();
    chk("held rst early", cur_src, 3'd0);
    lat = 0;
    while (cur_src == 3'd0 && lat < 2) begin
      step();
      lat++;
    end
    chk("held rst adv", cur_src, 3'd1);
    chk("held rst disp", disp_data, exp_disp(32'h0, 3'd1));
    btn_next = 1'b0;
    repeat (10) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
